// File: rtl/monitor_carga_pkg.sv
// Shared definitions for the multi-channel battery charge monitor:
// class indices, FSM encoding and width helpers.
package monitor_carga_pkg;

    localparam logic [2:0] CRITICA   = 3'd0;
    localparam logic [2:0] BAJA      = 3'd1;
    localparam logic [2:0] REGULAR   = 3'd2;
    localparam logic [2:0] ACEPTABLE = 3'd3;
    localparam logic [2:0] COMPLETA  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACUM = 2'd2,
        CLAS = 2'd3
    } estado_t;

    // Width of the channel total: one extra bit per doubling of channels.
    function automatic int suma_ancho(input int n_ch, input int w);
        return w + $clog2(n_ch);
    endfunction

    function automatic logic [4:0] clase_onehot(input logic [2:0] k);
        logic [4:0] oh;
        oh = 5'b00000;
        case (k)
            CRITICA:   oh = 5'b00001;
            BAJA:      oh = 5'b00010;
            REGULAR:   oh = 5'b00100;
            ACEPTABLE: oh = 5'b01000;
            COMPLETA:  oh = 5'b10000;
            default:   oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/monitor_carga_if.sv
// Bus between the battery-level sources, the charge monitor and the
// display/alarm logic.
interface monitor_carga_if
    import monitor_carga_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int W    = 4
);
    localparam int SW = suma_ancho(N_CH, W);

    logic                en;
    logic [N_CH*W-1:0]   niveles;
    logic [SW-1:0]       suma;
    logic [4:0]          nivel;
    logic [N_CH-1:0]     descargada;
    logic                alarma;
    logic                valido;

    modport master (
        output en, niveles,
        input  suma, nivel, descargada, alarma, valido
    );

    modport slave (
        input  en, niveles,
        output suma, nivel, descargada, alarma, valido
    );

endinterface

// File: rtl/clasificador_carga.sv
// Maps a channel total to a charge class, holding the current class
// unless the total falls clearly below its lower bound.
module clasificador_carga
    import monitor_carga_pkg::*;
#(
    parameter int SW   = 5,
    parameter int TH1  = 4,
    parameter int TH2  = 10,
    parameter int TH3  = 18,
    parameter int TH4  = 26,
    parameter int HYST = 1
) (
    input  logic [SW-1:0] s,
    input  logic [2:0]    actual,
    output logic [2:0]    candidato
);

    logic [31:0] s_ext_s;
    logic [31:0] lb_s;
    logic [2:0]  bruta_s;

    assign s_ext_s = 32'(s);

    // Raw class from fixed thresholds.
    always_comb begin
        bruta_s = CRITICA;
        if (s_ext_s < 32'(TH1)) begin
            bruta_s = CRITICA;
        end else if (s_ext_s < 32'(TH2)) begin
            bruta_s = BAJA;
        end else if (s_ext_s < 32'(TH3)) begin
            bruta_s = REGULAR;
        end else if (s_ext_s < 32'(TH4)) begin
            bruta_s = ACEPTABLE;
        end else begin
            bruta_s = COMPLETA;
        end
    end

    // Lower bound of the class currently displayed.
    always_comb begin
        lb_s = 32'd0;
        case (actual)
            BAJA:      lb_s = 32'(TH1);
            REGULAR:   lb_s = 32'(TH2);
            ACEPTABLE: lb_s = 32'(TH3);
            COMPLETA:  lb_s = 32'(TH4);
            default:   lb_s = 32'd0;
        endcase
    end

    // Downward moves must clear the margin; the guard avoids wrapping below zero.
    always_comb begin
        candidato = bruta_s;
        if (bruta_s < actual) begin
            if ((lb_s >= 32'(HYST)) && (s_ext_s < (lb_s - 32'(HYST)))) begin
                candidato = bruta_s;
            end else begin
                candidato = actual;
            end
        end else begin
            candidato = bruta_s;
        end
    end

endmodule

// File: rtl/monitor_carga_n.sv
// N-channel battery charge monitor: snapshot, serial accumulation,
// classification with hysteresis and debounce, discharge flags and alarm.
module monitor_carga_n
    import monitor_carga_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int W    = 4,
    parameter int DEB  = 2,
    parameter int HYST = 1,
    parameter int TH1  = 4,
    parameter int TH2  = 10,
    parameter int TH3  = 18,
    parameter int TH4  = 26
) (
    input  logic            clk,
    input  logic            rst,
    monitor_carga_if.slave  bus
);

    localparam int SW = suma_ancho(N_CH, W);
    localparam int IW = $clog2(N_CH);
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

    estado_t             estado_r;
    estado_t             estado_s;
    logic [N_CH*W-1:0]   foto_r;
    logic [SW-1:0]       acc_r;
    logic [IW-1:0]       idx_r;
    logic [N_CH-1:0]     desc_acc_r;
    logic [W-1:0]        canal_s;
    logic                ultimo_s;

    logic [2:0]          clase_r;
    logic [2:0]          clase_s;
    logic [2:0]          pend_r;
    logic [2:0]          pend_s;
    logic [2:0]          cand_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_s;
    logic                primero_r;
    logic                primero_s;

    logic [SW-1:0]       suma_r;
    logic [4:0]          nivel_r;
    logic [N_CH-1:0]     desc_r;
    logic                alarma_r;
    logic                valido_r;

    assign canal_s  = foto_r[32'(idx_r) * W +: W];
    assign ultimo_s = (idx_r == IW'(N_CH - 1));

    clasificador_carga #(
        .SW   (SW),
        .TH1  (TH1),
        .TH2  (TH2),
        .TH3  (TH3),
        .TH4  (TH4),
        .HYST (HYST)
    ) u_clasificador (
        .s         (acc_r),
        .actual    (clase_r),
        .candidato (cand_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_s;
        end
    end

    // FSM next state; a scan always runs to completion once captured.
    always_comb begin
        estado_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (bus.en) begin
                    estado_s = CAPT;
                end else begin
                    estado_s = IDLE;
                end
            end
            CAPT: estado_s = ACUM;
            ACUM: begin
                if (ultimo_s) begin
                    estado_s = CLAS;
                end else begin
                    estado_s = ACUM;
                end
            end
            CLAS: begin
                if (bus.en) begin
                    estado_s = CAPT;
                end else begin
                    estado_s = IDLE;
                end
            end
            default: estado_s = IDLE;
        endcase
    end

    // Debounce: a new class is adopted only after DEB consecutive agreeing scans.
    always_comb begin
        clase_s   = clase_r;
        pend_s    = pend_r;
        cnt_s     = cnt_r;
        primero_s = primero_r;
        if (estado_r == CLAS) begin
            if (primero_r) begin
                clase_s   = cand_s;
                pend_s    = cand_s;
                cnt_s     = CW'(0);
                primero_s = 1'b0;
            end else if (cand_s == clase_r) begin
                cnt_s = CW'(0);
            end else if (cand_s == pend_r) begin
                if ((32'(cnt_r) + 32'd1) >= 32'(DEB - 1)) begin
                    clase_s = cand_s;
                    cnt_s   = CW'(0);
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end else begin
                pend_s = cand_s;
                cnt_s  = CW'(0);
                if (DEB == 1) begin
                    clase_s = cand_s;
                end else begin
                    clase_s = clase_r;
                end
            end
        end else begin
            clase_s = clase_r;
        end
    end

    // Datapath: snapshot, serial accumulation and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            foto_r     <= {(N_CH*W){1'b0}};
            acc_r      <= {SW{1'b0}};
            idx_r      <= {IW{1'b0}};
            desc_acc_r <= {N_CH{1'b0}};
            clase_r    <= CRITICA;
            pend_r     <= CRITICA;
            cnt_r      <= CW'(0);
            primero_r  <= 1'b1;
            suma_r     <= {SW{1'b0}};
            nivel_r    <= 5'b00000;
            desc_r     <= {N_CH{1'b0}};
            alarma_r   <= 1'b0;
            valido_r   <= 1'b0;
        end else begin
            clase_r   <= clase_s;
            pend_r    <= pend_s;
            cnt_r     <= cnt_s;
            primero_r <= primero_s;
            case (estado_r)
                CAPT: begin
                    foto_r     <= bus.niveles;
                    acc_r      <= {SW{1'b0}};
                    idx_r      <= {IW{1'b0}};
                    desc_acc_r <= {N_CH{1'b0}};
                    valido_r   <= 1'b0;
                end
                ACUM: begin
                    acc_r             <= acc_r + SW'(canal_s);
                    desc_acc_r[idx_r] <= (canal_s == {W{1'b0}});
                    idx_r             <= idx_r + IW'(1);
                    valido_r          <= 1'b0;
                end
                CLAS: begin
                    suma_r   <= acc_r;
                    desc_r   <= desc_acc_r;
                    nivel_r  <= clase_onehot(clase_s);
                    alarma_r <= (clase_s == CRITICA);
                    valido_r <= 1'b1;
                end
                default: begin
                    valido_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.suma       = suma_r;
    assign bus.nivel      = nivel_r;
    assign bus.descargada = desc_r;
    assign bus.alarma     = alarma_r;
    assign bus.valido     = valido_r;

endmodule

// File: tb/tb_monitor_carga_n.sv
// Directed self-checking bench for monitor_carga_n at default parameters.
module tb_monitor_carga_n;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    monitor_carga_if #(.N_CH(2), .W(4)) bus ();

    monitor_carga_n #(
        .N_CH(2), .W(4), .DEB(2), .HYST(1),
        .TH1(4), .TH2(10), .TH3(18), .TH4(26)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_niveles(input logic [3:0] c0, input logic [3:0] c1);
        bus.niveles = {c1, c0};
    endtask

    // Counts rising edges until valido is seen; 99 means it never came.
    task automatic wait_valido(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                n = n + 1;
                if (bus.valido === 1'b1) seen = 1'b1;
            end
        end
        if (!seen) n = 99;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        set_niveles(4'd0, 4'd0);
        #2;
        checks++;
        if ({bus.suma, bus.nivel, bus.descargada, bus.alarma, bus.valido} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=0",
                     {bus.suma, bus.nivel, bus.descargada, bus.alarma, bus.valido});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.suma, bus.nivel, bus.descargada, bus.alarma, bus.valido} !== 14'd0) begin
            failures++;
            $display("FAIL reset_held got=%b expected=0",
                     {bus.suma, bus.nivel, bus.descargada, bus.alarma, bus.valido});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_scan();
        int n;
        set_niveles(4'd15, 4'd15);
        bus.en = 1'b1;
        wait_valido(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL first_latency got=%0d expected=5", n); end
        checks++;
        if (bus.suma !== 5'd30) begin failures++; $display("FAIL first_suma got=%0d expected=30", bus.suma); end
        checks++;
        if (bus.nivel !== 5'b10000) begin failures++; $display("FAIL first_nivel got=%b expected=10000", bus.nivel); end
        checks++;
        if (bus.descargada !== 2'b00) begin failures++; $display("FAIL first_desc got=%b expected=00", bus.descargada); end
        checks++;
        if (bus.alarma !== 1'b0) begin failures++; $display("FAIL first_alarma got=%b expected=0", bus.alarma); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valido !== 1'b0) begin failures++; $display("FAIL valido_pulse got=%b expected=0", bus.valido); end
        wait_valido(n);
        checks++;
        if (n !== 3) begin failures++; $display("FAIL scan_period got=%0d expected=3 after pulse", n); end
    endtask

    task automatic test_debounce_down();
        int n;
        set_niveles(4'd0, 4'd3);
        wait_valido(n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL down1_latency got=%0d expected=4", n); end
        checks++;
        if (bus.suma !== 5'd3) begin failures++; $display("FAIL down1_suma got=%0d expected=3", bus.suma); end
        checks++;
        if (bus.descargada !== 2'b01) begin failures++; $display("FAIL down1_desc got=%b expected=01", bus.descargada); end
        checks++;
        if (bus.nivel !== 5'b10000) begin failures++; $display("FAIL down1_nivel got=%b expected=10000", bus.nivel); end
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00001) begin failures++; $display("FAIL down2_nivel got=%b expected=00001", bus.nivel); end
        checks++;
        if (bus.alarma !== 1'b1) begin failures++; $display("FAIL down2_alarma got=%b expected=1", bus.alarma); end
    endtask

    task automatic test_hysteresis();
        int n;
        set_niveles(4'd6, 4'd6);
        wait_valido(n);
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00100) begin failures++; $display("FAIL hyst_settle got=%b expected=00100", bus.nivel); end
        checks++;
        if (bus.alarma !== 1'b0) begin failures++; $display("FAIL hyst_alarma got=%b expected=0", bus.alarma); end
        set_niveles(4'd4, 4'd5);
        wait_valido(n);
        checks++;
        if (bus.suma !== 5'd9) begin failures++; $display("FAIL hyst9_suma got=%0d expected=9", bus.suma); end
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00100) begin failures++; $display("FAIL hyst9_hold got=%b expected=00100", bus.nivel); end
        set_niveles(4'd4, 4'd4);
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00100) begin failures++; $display("FAIL hyst8_scan1 got=%b expected=00100", bus.nivel); end
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00010) begin failures++; $display("FAIL hyst8_scan2 got=%b expected=00010", bus.nivel); end
    endtask

    task automatic test_interrupted();
        int n;
        set_niveles(4'd10, 4'd10);
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00010) begin failures++; $display("FAIL intr_s20 got=%b expected=00010", bus.nivel); end
        set_niveles(4'd6, 4'd6);
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00010) begin failures++; $display("FAIL intr_s12a got=%b expected=00010", bus.nivel); end
        wait_valido(n);
        checks++;
        if (bus.nivel !== 5'b00100) begin failures++; $display("FAIL intr_s12b got=%b expected=00100", bus.nivel); end
    endtask

    task automatic test_en_drop();
        int n;
        int pulses;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        wait_valido(n);
        checks++;
        if (n !== 3) begin failures++; $display("FAIL endrop_finish got=%0d expected=3", n); end
        checks++;
        if (bus.suma !== 5'd12) begin failures++; $display("FAIL endrop_suma got=%0d expected=12", bus.suma); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.valido === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL endrop_idle got=%0d pulses expected=0", pulses); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        int pulses;
        bus.en = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.suma, bus.nivel, bus.descargada, bus.alarma, bus.valido} !== 14'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b expected=0",
                     {bus.suma, bus.nivel, bus.descargada, bus.alarma, bus.valido});
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.valido !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL midrst_novalido got=%0d expected=0", pulses); end
        set_niveles(4'd15, 4'd15);
        rst = 1'b0;
        wait_valido(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL midrst_latency got=%0d expected=5", n); end
        checks++;
        if (bus.nivel !== 5'b10000) begin failures++; $display("FAIL midrst_nivel got=%b expected=10000", bus.nivel); end
        checks++;
        if (bus.suma !== 5'd30) begin failures++; $display("FAIL midrst_suma got=%0d expected=30", bus.suma); end
        checks++;
        if (bus.alarma !== 1'b0) begin failures++; $display("FAIL midrst_alarma got=%b expected=0", bus.alarma); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_scan();
        test_debounce_down();
        test_hysteresis();
        test_interrupted();
        test_en_drop();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
